led_timing_generator: RTL
=========================

LED_TIMING_GENERATOR -- requirements
Module: led_timing_generator

Interface
REQ-001 SHALL have parameter SEGMENT_DIVIDER, default 4, meaning clocks per bit segment (3 MHz at 12 MHz); legal range >=2.
REQ-002 SHALL have parameter SEGMENTS_PER_BIT, default 4, meaning segments per LED data bit; legal range >=2.
REQ-003 SHALL have parameter BITS_PER_LED, default 24, meaning data bits per LED; legal range >=1.
REQ-004 SHALL have parameter LED_COUNT, default 150, meaning LEDs per frame; legal range 1..1023.
REQ-005 SHALL have parameter LATCH_CYCLES, default 600, meaning idle-low latch gap in clocks after the last bit; legal range >=1.
REQ-006 SHALL have parameter FRAME_PERIOD, default 200002, meaning clocks between free-run frame starts; legal range > frame length.
REQ-007 SHALL have port clock_12mhz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1 bit: permits new frames to start.
REQ-010 SHALL have port mode, input, 1 bit: 0 = free-run on internal frame timer, 1 = start on frame_trigger.
REQ-011 SHALL have port frame_trigger, input, 1 bit: frame request in mode 1, sampled every clock.
REQ-012 SHALL have port segment_strobe, output, 1 bit: one-clock pulse at the start of every segment.
REQ-013 SHALL have port segment_index, output, clog2(SEGMENTS_PER_BIT) bits: current segment within the bit.
REQ-014 SHALL have port bit_strobe, output, 1 bit: one-clock pulse at the start of every bit.
REQ-015 SHALL have port bit_index, output, clog2(BITS_PER_LED) bits: current bit within the LED, MSB-first order 0..BITS_PER_LED-1.
REQ-016 SHALL have port encoder_reset, output, 1 bit: one-clock pulse at the start of every LED.
REQ-017 SHALL have port led_index, output, 10 bits: current LED number.
REQ-018 SHALL have port frame_start, output, 1 bit: one-clock pulse when a frame is accepted.
REQ-019 SHALL have port frame_done, output, 1 bit: one-clock pulse in the last latch cycle.
REQ-020 SHALL have port busy, output, 1 bit: high in ACTIVE and LATCH.
REQ-021 SHALL have port dropped_frames, output, 8 bits: saturating count of requests rejected while busy.

Function
REQ-022 SHALL implement states IDLE, ACTIVE, LATCH; transitions IDLE->ACTIVE on accepted request, ACTIVE->LATCH after the last segment of LED LED_COUNT-1, LATCH->IDLE after LATCH_CYCLES clocks.
REQ-023 SHALL define a request as: mode 0, frame timer equal to FRAME_PERIOD-1; mode 1, frame_trigger high. A request is accepted only when in IDLE with enable high.
REQ-024 SHALL pulse frame_start in the request cycle T and enter ACTIVE at T+1 with all indices 0, and segment_strobe, bit_strobe and encoder_reset high together at T+1.
REQ-025 SHALL pulse segment_strobe every SEGMENT_DIVIDER clocks in ACTIVE; indices SHALL advance in the strobe cycle and hold between strobes.
REQ-026 SHALL wrap segment_index to 0 after SEGMENTS_PER_BIT-1, advancing bit_index; bit_index SHALL wrap after BITS_PER_LED-1, advancing led_index.
REQ-027 SHALL keep ACTIVE for exactly LED_COUNT*BITS_PER_LED*SEGMENTS_PER_BIT*SEGMENT_DIVIDER clocks; no strobes SHALL occur in LATCH or IDLE.
REQ-028 SHALL hold indices at 0 in IDLE and LATCH.
REQ-029 SHALL run the frame timer 0..FRAME_PERIOD-1, wrapping, only while enable high and mode 0; otherwise it SHALL be held at 0.
REQ-030 SHALL increment dropped_frames, saturating at 255, for every request while busy with enable high; in mode 1, each cycle trigger is high counts.
REQ-031 SHALL NOT abort a frame in progress when enable falls or mode changes; both take effect in IDLE only.
REQ-032 SHALL derive every strobe from counters in the clock_12mhz domain; no generated clocks.

Reset
REQ-033 SHALL, with reset_n low, force IDLE; all strobes, busy, indices, frame timer and dropped_frames to 0, regardless of clock.
REQ-034 SHALL, on reset_n assertion mid-frame, abandon the frame immediately; no frame_done SHALL be produced.

Verification (SEGMENT_DIVIDER=2, SEGMENTS_PER_BIT=2, BITS_PER_LED=3, LED_COUNT=2, LATCH_CYCLES=4, FRAME_PERIOD=40)
REQ-035 SHALL check mode 1: trigger at T -> frame_start T; busy T+1..T+28; encoder_reset at T+1 and T+13; bit_strobe every 4 clocks; frame_done at T+28.
REQ-036 SHALL check mode 0: enable high from reset release (cycle 0) -> frame_start at cycles 39, 79, 119; dropped_frames stays 0.
REQ-037 SHALL check overrun: mode 1, triggers at T and T+5..T+7 -> one frame; dropped_frames=3; trigger at T+29 is accepted.
REQ-038 SHALL check saturation: 300 rejected trigger cycles -> dropped_frames=255.
REQ-039 SHALL check enable drop at T+10 mid-frame -> frame completes, frame_done at T+28; no new frame starts while enable low.
REQ-040 SHALL check reset_n low at T+15 -> outputs 0 asynchronously; after release, the first trigger gives a clean frame with indices starting at 0.

Source files
------------

// File: rtl/led_timing_generator.sv
// LED frame timing: segment, bit and LED strobes with indices, latch gap,
// free-run or triggered frame starts and a saturating overrun counter.
module led_timing_generator #(
    parameter int SEGMENT_DIVIDER  = 4,
    parameter int SEGMENTS_PER_BIT = 4,
    parameter int BITS_PER_LED     = 24,
    parameter int LED_COUNT        = 150,
    parameter int LATCH_CYCLES     = 600,
    parameter int FRAME_PERIOD     = 200002,
    localparam int SW = (SEGMENTS_PER_BIT > 1) ? $clog2(SEGMENTS_PER_BIT) : 1,
    localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1
) (
    input  logic          clock_12mhz,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          mode,
    input  logic          frame_trigger,
    output logic          segment_strobe,
    output logic [SW-1:0] segment_index,
    output logic          bit_strobe,
    output logic [BW-1:0] bit_index,
    output logic          encoder_reset,
    output logic [9:0]    led_index,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy,
    output logic [7:0]    dropped_frames
);

    localparam int DW = (SEGMENT_DIVIDER > 1) ? $clog2(SEGMENT_DIVIDER) : 1;
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SEGMENT_DIVIDER - 1);
    localparam logic [SW-1:0] SEG_LAST   = SW'(SEGMENTS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_LED - 1);
    localparam logic [9:0]    LED_LAST   = 10'(LED_COUNT - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        LATCH
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div_cnt;
    logic [LW-1:0] latch_cnt;
    logic [TW-1:0] frame_timer;

    logic request;
    logic accept;
    logic last_div;
    logic last_seg;
    logic last_bit;
    logic last_led;
    logic end_active;
    logic end_latch;

    always_comb begin
        request    = mode ? frame_trigger : (frame_timer == FRAME_LAST);
        accept     = (state == IDLE) && enable && request;
        last_div   = (div_cnt == DIV_LAST);
        last_seg   = (segment_index == SEG_LAST);
        last_bit   = (bit_index == BIT_LAST);
        last_led   = (led_index == LED_LAST);
        end_active = (state == ACTIVE) && last_div && last_seg
                     && last_bit && last_led;
        end_latch  = (state == LATCH) && (latch_cnt == LATCH_LAST);
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)     state_nx = ACTIVE;
            ACTIVE:  if (end_active) state_nx = LATCH;
            LATCH:   if (end_latch)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Indices step on the clock before each strobe so they change with it.
    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt       <= '0;
            segment_index <= '0;
            bit_index     <= '0;
            led_index     <= '0;
        end else if (state == ACTIVE && !end_active) begin
            if (last_div) begin
                div_cnt <= '0;
                if (last_seg) begin
                    segment_index <= '0;
                    if (last_bit) begin
                        bit_index <= '0;
                        led_index <= led_index + 1'b1;
                    end else begin
                        bit_index <= bit_index + 1'b1;
                    end
                end else begin
                    segment_index <= segment_index + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            div_cnt       <= '0;
            segment_index <= '0;
            bit_index     <= '0;
            led_index     <= '0;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            latch_cnt <= '0;
        end else if (state == LATCH && !end_latch) begin
            latch_cnt <= latch_cnt + 1'b1;
        end else begin
            latch_cnt <= '0;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            frame_timer <= '0;
        end else if (enable && !mode) begin
            if (frame_timer == FRAME_LAST) begin
                frame_timer <= '0;
            end else begin
                frame_timer <= frame_timer + 1'b1;
            end
        end else begin
            frame_timer <= '0;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            dropped_frames <= '0;
        end else if (busy && enable && request
                     && dropped_frames != 8'hff) begin
            dropped_frames <= dropped_frames + 1'b1;
        end
    end

    // frame_start is combinational on the request, so gate it with reset.
    always_comb begin
        busy           = (state != IDLE);
        segment_strobe = (state == ACTIVE) && (div_cnt == '0);
        bit_strobe     = segment_strobe && (segment_index == '0);
        encoder_reset  = bit_strobe && (bit_index == '0);
        frame_start    = accept && reset_n;
        frame_done     = end_latch;
    end

endmodule
